// File: rtl/axi_err_log_pkg.sv
// Shared types and constants for the terminating AXI error-logging subordinate.
// Default AXI structs describe a 1-bit ID, 48-bit address, 64-bit data bus.
package axi_err_log_pkg;

  localparam int unsigned TimestampWidth  = 32;
  localparam logic [63:0] RespDataDefault = 64'hBADCAB1E_BADCAB1E;
  localparam logic [1:0]  RespDecerr      = 2'b11;

  localparam int unsigned DfltIdWidth   = 1;
  localparam int unsigned DfltAddrWidth = 48;
  localparam int unsigned DfltDataWidth = 64;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef struct packed {
    logic [DfltIdWidth-1:0]   id;
    logic [DfltAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [5:0]               atop;
  } dflt_aw_chan_t;

  typedef struct packed {
    logic [DfltDataWidth-1:0]   data;
    logic [DfltDataWidth/8-1:0] strb;
    logic                       last;
  } dflt_w_chan_t;

  typedef struct packed {
    logic [DfltIdWidth-1:0] id;
    logic [1:0]             resp;
  } dflt_b_chan_t;

  typedef struct packed {
    logic [DfltIdWidth-1:0]   id;
    logic [DfltAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
  } dflt_ar_chan_t;

  typedef struct packed {
    logic [DfltIdWidth-1:0]   id;
    logic [DfltDataWidth-1:0] data;
    logic [1:0]               resp;
    logic                     last;
  } dflt_r_chan_t;

  typedef struct packed {
    dflt_aw_chan_t aw;
    logic          aw_valid;
    dflt_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    dflt_ar_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } dflt_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    dflt_b_chan_t b;
    logic         r_valid;
    dflt_r_chan_t r;
  } dflt_axi_resp_t;

endpackage

// File: rtl/axi_err_log_capture.sv
// Fault counter and first-fault record; a clear is applied before same-cycle handshakes.
// Optional cycle timestamp of the capturing handshake under AXI_ERR_LOG_TIMESTAMP_EN.
module axi_err_log_capture import axi_err_log_pkg::*; #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 wr_hs_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [IdWidth-1:0]   wr_id_i,
  input  logic                 rd_hs_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  input  logic [IdWidth-1:0]   rd_id_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [IdWidth-1:0]   err_id_o,
  output logic                 err_is_write_o,
  output logic [CntWidth-1:0]  err_count_o
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
  ,
  output logic [TimestampWidth-1:0] err_time_o
`endif
);

  // One extra bit catches the overflow of adding up to two handshakes.
  localparam int unsigned SumWidth = CntWidth + 1;

  logic                 valid_q, valid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic                 wr_q, wr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [SumWidth-1:0]  cnt_sum;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
  logic [TimestampWidth-1:0] cyc_q, time_q, time_d;
`endif

  always_comb begin
    cnt_sum = (clr_i ? '0 : SumWidth'(cnt_q)) + SumWidth'(wr_hs_i) + SumWidth'(rd_hs_i);
    cnt_d   = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
    valid_d = valid_q & ~clr_i;
    addr_d  = clr_i ? '0 : addr_q;
    id_d    = clr_i ? '0 : id_q;
    wr_d    = wr_q & ~clr_i;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    time_d  = clr_i ? '0 : time_q;
`endif
    // Record the first fault after any clear; the write channel wins a tie.
    if (!valid_d && (wr_hs_i || rd_hs_i)) begin
      valid_d = 1'b1;
      addr_d  = wr_hs_i ? wr_addr_i : rd_addr_i;
      id_d    = wr_hs_i ? wr_id_i : rd_id_i;
      wr_d    = wr_hs_i;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
      time_d  = cyc_q;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
      cyc_q   <= '0;
      time_q  <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
      cyc_q   <= cyc_q + TimestampWidth'(1);
      time_q  <= time_d;
`endif
    end
  end

  assign err_valid_o    = valid_q;
  assign err_addr_o     = addr_q;
  assign err_id_o       = id_q;
  assign err_is_write_o = wr_q;
  assign err_count_o    = cnt_q;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
  assign err_time_o     = time_q;
`endif

endmodule

// File: rtl/axi_err_log_slv.sv
// Terminating AXI subordinate: drains every AW/W and AR, answers with an error, logs faults.
// Define AXI_ERR_LOG_TIMESTAMP_EN to add the err_time_o cycle timestamp of the first fault.
module axi_err_log_slv import axi_err_log_pkg::*; #(
  parameter int unsigned AxiIdWidth   = 1,
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned CntWidth     = 16,
  parameter logic [1:0]  Resp         = RespDecerr,
  parameter logic [63:0] RespData     = RespDataDefault,
  parameter type         axi_req_t    = dflt_axi_req_t,
  parameter type         axi_resp_t   = dflt_axi_resp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                slv_req_i,
  output axi_resp_t               slv_resp_o,
  input  logic                    clr_i,
  output logic                    err_valid_o,
  output logic [AxiAddrWidth-1:0] err_addr_o,
  output logic [AxiIdWidth-1:0]   err_id_o,
  output logic                    err_is_write_o,
  output logic [CntWidth-1:0]     err_count_o
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
  ,
  output logic [TimestampWidth-1:0] err_time_o
`endif
);

  localparam int unsigned BeatWidth = 8;
  localparam int unsigned DataWidth = $bits(slv_resp_o.r.data);

  w_state_e              w_state_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [AxiIdWidth-1:0] b_id_q;

  r_state_e              r_state_q;
  logic                  ar_ready_q, r_valid_q, r_last_q;
  logic [AxiIdWidth-1:0] r_id_q;
  logic [BeatWidth-1:0]  r_len_q, beat_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_req;

  assign aw_hs = slv_req_i.aw_valid & aw_ready_q;
  assign w_hs  = slv_req_i.w_valid & w_ready_q;
  assign b_hs  = b_valid_q & slv_req_i.b_ready;
  assign ar_hs = slv_req_i.ar_valid & ar_ready_q;
  assign r_hs  = r_valid_q & slv_req_i.r_ready;

  // Payload, strobes, atop and most attributes are intentionally ignored.
  assign unused_req = ^slv_req_i;

  // Write channel: accept AW, sink W until last, then hold B until taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          w_state_q  <= W_DATA;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
          b_id_q     <= slv_req_i.aw.id;
        end
        W_DATA: if (w_hs && slv_req_i.w.last) begin
          w_state_q <= W_RESP;
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
        end
        W_RESP: if (b_hs) begin
          w_state_q  <= W_IDLE;
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
        end
        default: begin
          w_state_q  <= W_IDLE;
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel: accept AR, then stream len+1 error beats; r_last is precomputed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      beat_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_state_q  <= R_DATA;
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_id_q     <= slv_req_i.ar.id;
          r_len_q    <= slv_req_i.ar.len;
          beat_q     <= '0;
          r_last_q   <= (slv_req_i.ar.len == '0);
        end
        R_DATA: if (r_hs) begin
          if (r_last_q) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
          end else begin
            beat_q   <= beat_q + BeatWidth'(1);
            r_last_q <= ((beat_q + BeatWidth'(1)) == r_len_q);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_q;
    slv_resp_o.w_ready  = w_ready_q;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.b.id     = b_id_q;
    slv_resp_o.b.resp   = Resp;
    slv_resp_o.ar_ready = ar_ready_q;
    slv_resp_o.r_valid  = r_valid_q;
    slv_resp_o.r.id     = r_id_q;
    slv_resp_o.r.data   = DataWidth'(RespData);
    slv_resp_o.r.resp   = Resp;
    slv_resp_o.r.last   = r_last_q;
  end

  axi_err_log_capture #(
    .AddrWidth (AxiAddrWidth),
    .IdWidth   (AxiIdWidth),
    .CntWidth  (CntWidth)
  ) u_capture (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (clr_i),
    .wr_hs_i        (aw_hs),
    .wr_addr_i      (AxiAddrWidth'(slv_req_i.aw.addr)),
    .wr_id_i        (AxiIdWidth'(slv_req_i.aw.id)),
    .rd_hs_i        (ar_hs),
    .rd_addr_i      (AxiAddrWidth'(slv_req_i.ar.addr)),
    .rd_id_i        (AxiIdWidth'(slv_req_i.ar.id)),
    .err_valid_o    (err_valid_o),
    .err_addr_o     (err_addr_o),
    .err_id_o       (err_id_o),
    .err_is_write_o (err_is_write_o),
    .err_count_o    (err_count_o)
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    ,
    .err_time_o     (err_time_o)
`endif
  );

endmodule

// File: tb/tb_axi_err_log_slv.sv
// Directed self-checking bench for axi_err_log_slv (default build plus a CntWidth=2 instance).
module tb_axi_err_log_slv;
  import axi_err_log_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dflt_axi_req_t  req0, req1;
  dflt_axi_resp_t resp0, resp1;
  logic        clr0, clr1;
  logic        ev0, ev1, ew0, ew1;
  logic [47:0] ea0, ea1;
  logic [0:0]  eid0, eid1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
  logic [31:0] et0, et1;
  logic [31:0] tb_cyc = '0;
  always @(posedge clk) tb_cyc <= rst_n ? tb_cyc + 32'd1 : 32'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] ExpData = 64'hBADCAB1E_BADCAB1E;

  axi_err_log_slv dut0 (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req0), .slv_resp_o(resp0), .clr_i(clr0),
    .err_valid_o(ev0), .err_addr_o(ea0), .err_id_o(eid0), .err_is_write_o(ew0),
    .err_count_o(cnt0)
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    , .err_time_o(et0)
`endif
  );

  axi_err_log_slv #(.CntWidth(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req1), .slv_resp_o(resp1), .clr_i(clr1),
    .err_valid_o(ev1), .err_addr_o(ea1), .err_id_o(eid1), .err_is_write_o(ew1),
    .err_count_o(cnt1)
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    , .err_time_o(et1)
`endif
  );

  task automatic test_reset();
    req0 = '0; req1 = '0; clr0 = 1'b0; clr1 = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (resp0.aw_ready !== 1'b1) begin n_err++; $display("FAIL reset_aw_ready: got %b want 1", resp0.aw_ready); end
    n_cmp++; if (resp0.ar_ready !== 1'b1) begin n_err++; $display("FAIL reset_ar_ready: got %b want 1", resp0.ar_ready); end
    n_cmp++; if (resp0.w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %b want 0", resp0.w_ready); end
    n_cmp++; if (resp0.b_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", resp0.b_valid); end
    n_cmp++; if (resp0.r_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_valid: got %b want 0", resp0.r_valid); end
    n_cmp++; if (resp0.r.last !== 1'b0) begin n_err++; $display("FAIL reset_r_last: got %b want 0", resp0.r.last); end
    n_cmp++; if (ev0 !== 1'b0) begin n_err++; $display("FAIL reset_err_valid: got %b want 0", ev0); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    n_cmp++; if (cnt1 !== 2'd0) begin n_err++; $display("FAIL reset_count_sat: got %0d want 0", cnt1); end
    rst_n = 1'b1;
    @(negedge clk);
    // A W beat with no AW must be refused.
    req0.w_valid = 1'b1; req0.w.last = 1'b1;
    @(negedge clk);
    n_cmp++; if (resp0.w_ready !== 1'b0) begin n_err++; $display("FAIL early_w_ready: got %b want 0", resp0.w_ready); end
    n_cmp++; if (resp0.b_valid !== 1'b0) begin n_err++; $display("FAIL early_w_b_valid: got %b want 0", resp0.b_valid); end
    req0.w_valid = 1'b0; req0.w.last = 1'b0;
  endtask

  task automatic test_write();
    req0.aw_valid = 1'b1; req0.aw.id = 1'b1; req0.aw.addr = 48'h1000; req0.aw.len = 8'd3;
    @(negedge clk);
    req0.aw_valid = 1'b0;
    n_cmp++; if (resp0.w_ready !== 1'b1) begin n_err++; $display("FAIL wr_w_ready: got %b want 1", resp0.w_ready); end
    n_cmp++; if (resp0.aw_ready !== 1'b0) begin n_err++; $display("FAIL wr_aw_ready_busy: got %b want 0", resp0.aw_ready); end
    n_cmp++; if (ev0 !== 1'b1) begin n_err++; $display("FAIL wr_err_valid: got %b want 1", ev0); end
    n_cmp++; if (ea0 !== 48'h1000) begin n_err++; $display("FAIL wr_err_addr: got %h want 1000", ea0); end
    n_cmp++; if (ew0 !== 1'b1) begin n_err++; $display("FAIL wr_err_is_write: got %b want 1", ew0); end
    n_cmp++; if (eid0 !== 1'b1) begin n_err++; $display("FAIL wr_err_id: got %b want 1", eid0); end
    n_cmp++; if (cnt0 !== 16'd1) begin n_err++; $display("FAIL wr_count: got %0d want 1", cnt0); end
    for (int i = 0; i < 4; i++) begin
      req0.w_valid = 1'b1; req0.w.last = (i == 3); req0.w.data = 64'(i);
      @(negedge clk);
      n_cmp++; if (resp0.b_valid !== (i == 3)) begin n_err++; $display("FAIL wr_b_valid_beat%0d: got %b want %b", i, resp0.b_valid, (i == 3)); end
    end
    req0.w_valid = 1'b0; req0.w.last = 1'b0;
    n_cmp++; if (resp0.b.id !== 1'b1) begin n_err++; $display("FAIL wr_b_id: got %b want 1", resp0.b.id); end
    n_cmp++; if (resp0.b.resp !== 2'b11) begin n_err++; $display("FAIL wr_b_resp: got %b want 11", resp0.b.resp); end
    n_cmp++; if (resp0.w_ready !== 1'b0) begin n_err++; $display("FAIL wr_w_ready_done: got %b want 0", resp0.w_ready); end
    @(negedge clk);
    n_cmp++; if (resp0.b_valid !== 1'b1) begin n_err++; $display("FAIL wr_b_hold: got %b want 1", resp0.b_valid); end
    req0.b_ready = 1'b1;
    @(negedge clk);
    req0.b_ready = 1'b0;
    n_cmp++; if (resp0.b_valid !== 1'b0) begin n_err++; $display("FAIL wr_b_drop: got %b want 0", resp0.b_valid); end
    n_cmp++; if (resp0.aw_ready !== 1'b1) begin n_err++; $display("FAIL wr_aw_ready_back: got %b want 1", resp0.aw_ready); end
  endtask

  task automatic test_read();
    int beat;
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n_cmp++; if (ev0 !== 1'b0) begin n_err++; $display("FAIL clr_err_valid: got %b want 0", ev0); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", cnt0); end
    req0.ar_valid = 1'b1; req0.ar.id = 1'b0; req0.ar.addr = 48'h5000; req0.ar.len = 8'd7;
    @(negedge clk);
    req0.ar_valid = 1'b0;
    n_cmp++; if (resp0.ar_ready !== 1'b0) begin n_err++; $display("FAIL rd_ar_ready_busy: got %b want 0", resp0.ar_ready); end
    n_cmp++; if (ew0 !== 1'b0 || ea0 !== 48'h5000) begin n_err++; $display("FAIL rd_record: got w=%b a=%h want w=0 a=5000", ew0, ea0); end
    n_cmp++; if (cnt0 !== 16'd1) begin n_err++; $display("FAIL rd_count: got %0d want 1", cnt0); end
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      n_cmp++; if (resp0.r_valid !== 1'b1) begin n_err++; $display("FAIL rd_r_valid c%0d: got %b want 1", c, resp0.r_valid); end
      n_cmp++; if (resp0.r.data !== ExpData || resp0.r.resp !== 2'b11 || resp0.r.id !== 1'b0) begin
        n_err++; $display("FAIL rd_payload c%0d: got %h/%b/%b want %h/11/0", c, resp0.r.data, resp0.r.resp, resp0.r.id, ExpData); end
      n_cmp++; if (resp0.r.last !== (beat == 7)) begin n_err++; $display("FAIL rd_r_last beat%0d: got %b want %b", beat, resp0.r.last, (beat == 7)); end
      req0.r_ready = (c % 2 == 1);
      @(negedge clk);
      if (req0.r_ready) beat++;
    end
    req0.r_ready = 1'b0;
    n_cmp++; if (beat != 8) begin n_err++; $display("FAIL rd_beats: got %0d want 8", beat); end
    n_cmp++; if (resp0.r_valid !== 1'b0) begin n_err++; $display("FAIL rd_r_valid_end: got %b want 0", resp0.r_valid); end
    n_cmp++; if (resp0.ar_ready !== 1'b1) begin n_err++; $display("FAIL rd_ar_ready_back: got %b want 1", resp0.ar_ready); end
  endtask

  task automatic test_simultaneous();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    req0.aw_valid = 1'b1; req0.aw.id = 1'b0; req0.aw.addr = 48'h2000; req0.aw.len = 8'd0;
    req0.ar_valid = 1'b1; req0.ar.id = 1'b1; req0.ar.addr = 48'h3000; req0.ar.len = 8'd1;
    @(negedge clk);
    req0.aw_valid = 1'b0; req0.ar_valid = 1'b0;
    n_cmp++; if (cnt0 !== 16'd2) begin n_err++; $display("FAIL sim_count: got %0d want 2", cnt0); end
    n_cmp++; if (ea0 !== 48'h2000 || ew0 !== 1'b1 || eid0 !== 1'b0) begin
      n_err++; $display("FAIL sim_record: got a=%h w=%b id=%b want a=2000 w=1 id=0", ea0, ew0, eid0); end
    n_cmp++; if (resp0.w_ready !== 1'b1 || resp0.r_valid !== 1'b1) begin
      n_err++; $display("FAIL sim_both_busy: got w_ready=%b r_valid=%b want 1 1", resp0.w_ready, resp0.r_valid); end
    req0.w_valid = 1'b1; req0.w.last = 1'b1; req0.r_ready = 1'b1; req0.b_ready = 1'b1;
    @(negedge clk);
    req0.w_valid = 1'b0; req0.w.last = 1'b0;
    n_cmp++; if (resp0.b_valid !== 1'b1 || resp0.r_valid !== 1'b1 || resp0.r.last !== 1'b1 || resp0.r.id !== 1'b1) begin
      n_err++; $display("FAIL sim_mid: got b_valid=%b r_valid=%b r_last=%b r_id=%b want 1 1 1 1", resp0.b_valid, resp0.r_valid, resp0.r.last, resp0.r.id); end
    @(negedge clk);
    req0.r_ready = 1'b0; req0.b_ready = 1'b0;
    n_cmp++; if (resp0.b_valid !== 1'b0 || resp0.r_valid !== 1'b0 || resp0.aw_ready !== 1'b1 || resp0.ar_ready !== 1'b1) begin
      n_err++; $display("FAIL sim_done: got b_valid=%b r_valid=%b aw_ready=%b ar_ready=%b want 0 0 1 1", resp0.b_valid, resp0.r_valid, resp0.aw_ready, resp0.ar_ready); end
    n_cmp++; if (cnt0 !== 16'd2) begin n_err++; $display("FAIL sim_count_hold: got %0d want 2", cnt0); end
  endtask

  task automatic test_clr_same_cycle();
    clr0 = 1'b1;
    req0.ar_valid = 1'b1; req0.ar.id = 1'b1; req0.ar.addr = 48'h4000; req0.ar.len = 8'd0;
    @(negedge clk);
    clr0 = 1'b0; req0.ar_valid = 1'b0;
    n_cmp++; if (cnt0 !== 16'd1) begin n_err++; $display("FAIL clr_hs_count: got %0d want 1", cnt0); end
    n_cmp++; if (ev0 !== 1'b1 || ea0 !== 48'h4000 || ew0 !== 1'b0 || eid0 !== 1'b1) begin
      n_err++; $display("FAIL clr_hs_record: got v=%b a=%h w=%b id=%b want 1 4000 0 1", ev0, ea0, ew0, eid0); end
    n_cmp++; if (resp0.r.last !== 1'b1) begin n_err++; $display("FAIL clr_hs_r_last: got %b want 1", resp0.r.last); end
    req0.r_ready = 1'b1;
    @(negedge clk);
    req0.r_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    for (int i = 0; i < 5; i++) begin
      req1.ar_valid = 1'b1; req1.ar.addr = 48'h100 * 48'(i + 1); req1.ar.len = 8'd0;
      @(negedge clk);
      req1.ar_valid = 1'b0; req1.r_ready = 1'b1;
      @(negedge clk);
      req1.r_ready = 1'b0;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (cnt1 !== exp_cnt) begin n_err++; $display("FAIL sat_count ar%0d: got %0d want %0d", i, cnt1, exp_cnt); end
    end
    n_cmp++; if (ea1 !== 48'h100 || ev1 !== 1'b1) begin n_err++; $display("FAIL sat_record: got v=%b a=%h want 1 100", ev1, ea1); end
  endtask

  task automatic test_reset_mid_burst();
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    logic [31:0] exp_t;
`endif
    req0.ar_valid = 1'b1; req0.ar.id = 1'b0; req0.ar.addr = 48'h6000; req0.ar.len = 8'd7;
    @(negedge clk);
    req0.ar_valid = 1'b0; req0.r_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (resp0.r_valid !== 1'b1 || resp0.r.last !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_beat3: got r_valid=%b r_last=%b want 1 0", resp0.r_valid, resp0.r.last); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp0.r_valid !== 1'b0 || resp0.ar_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_fsm: got r_valid=%b ar_ready=%b want 0 1", resp0.r_valid, resp0.ar_ready); end
    n_cmp++; if (cnt0 !== 16'd0 || ev0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_log: got cnt=%0d v=%b want 0 0", cnt0, ev0); end
    rst_n = 1'b1; req0.r_ready = 1'b0;
    @(negedge clk);
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    exp_t = tb_cyc;
`endif
    req0.ar_valid = 1'b1; req0.ar.id = 1'b1; req0.ar.addr = 48'h7000; req0.ar.len = 8'd1;
    @(negedge clk);
    req0.ar_valid = 1'b0;
    n_cmp++; if (resp0.r_valid !== 1'b1 || resp0.r.id !== 1'b1 || resp0.r.last !== 1'b0) begin
      n_err++; $display("FAIL rst_new_first: got v=%b id=%b last=%b want 1 1 0", resp0.r_valid, resp0.r.id, resp0.r.last); end
    n_cmp++; if (cnt0 !== 16'd1 || ea0 !== 48'h7000) begin n_err++; $display("FAIL rst_new_log: got cnt=%0d a=%h want 1 7000", cnt0, ea0); end
`ifdef AXI_ERR_LOG_TIMESTAMP_EN
    n_cmp++; if (et0 !== exp_t) begin n_err++; $display("FAIL rst_new_time: got %0d want %0d", et0, exp_t); end
`endif
    req0.r_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (resp0.r_valid !== 1'b1 || resp0.r.last !== 1'b1) begin
      n_err++; $display("FAIL rst_new_last: got v=%b last=%b want 1 1", resp0.r_valid, resp0.r.last); end
    @(negedge clk);
    req0.r_ready = 1'b0;
    n_cmp++; if (resp0.r_valid !== 1'b0 || resp0.ar_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_new_done: got r_valid=%b ar_ready=%b want 0 1", resp0.r_valid, resp0.ar_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_clr_same_cycle();
    test_saturation();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
